// File: rtl/memory_handshake_unit_pkg.sv
// Shared encodings for the memory handshake unit: access sizes, RW polarity,
// FSM states and the load-extension helper.
package memory_handshake_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // raw is big-endian: the byte at the access address sits in raw[31:24].
    function automatic logic [31:0] extend_load(input logic [1:0]  size,
                                                input logic        sext,
                                                input logic [31:0] raw);
        logic [31:0] result;
        case (size)
            SZ_BYTE: result = sext ? {{24{raw[31]}}, raw[31:24]} : {24'h0, raw[31:24]};
            SZ_HALF: result = sext ? {{16{raw[31]}}, raw[31:16]} : {16'h0, raw[31:16]};
            default: result = raw;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/memory_handshake_unit_if.sv
// MOV/MOC handshake bundle between the control unit (master) and the
// data-memory stage (slave).
interface memory_handshake_unit_if;
    logic        MOV;
    logic        RW;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        AlignErr;

    modport master (
        output MOV, RW, Size, SignExt, Address, DataIn,
        input  DataOut, MOC, AlignErr
    );

    modport slave (
        input  MOV, RW, Size, SignExt, Address, DataIn,
        output DataOut, MOC, AlignErr
    );
endinterface

// File: rtl/memory_handshake_unit_mem_byte_array.sv
// Big-endian byte array: four-lane byte-enable synchronous write and a
// combinational four-byte read, lane addresses wrapping modulo 2**ADDR_W.
module mem_byte_array #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,     // be[3] selects the byte at addr
    input  logic [31:0]       wdata,  // wdata[31:24] goes to addr
    output logic [31:0]       rdata
);

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] lane_addr [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr + ADDR_W'(k);
        end
    end

    // NOTE: storage has no reset; clearing a RAM would force flops instead of
    // a memory macro. Sequential writes use non-blocking assignment.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (be[3-k]) begin
                mem[lane_addr[k]] <= wdata[31-8*k -: 8];
            end
        end
    end

    assign rdata = {mem[lane_addr[0]], mem[lane_addr[1]],
                    mem[lane_addr[2]], mem[lane_addr[3]]};

endmodule

// File: rtl/memory_handshake_unit.sv
// Data-memory stage closing the MOV/MOC handshake with programmable wait states.
// Define MEM_ALIGN_CHECK_EN to flag misaligned accesses instead of aligning them.
module memory_handshake_unit
    import memory_handshake_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                    Clk,
    input  logic                    Clr,
    memory_handshake_unit_if.slave  bus
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q, eff_addr;
    logic              rw_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [31:0]       din_q;
    logic [31:0]       data_out_q;
    logic              moc_q;
    logic              align_err_q;
    logic              accept, access, misalign;
    logic [3:0]        lane_be, be;
    logic [31:0]       wdata, rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^bus.Address[31:ADDR_W];

    always_ff @(posedge Clk) begin
        if (Clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.MOV) begin
                accept  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: if (cnt_q == 4'd0) begin
                access  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: if (!bus.MOV) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane packing and alignment of the latched request.
    always_comb begin
        eff_addr = addr_q;
        misalign = 1'b0;
        wdata    = din_q;
        lane_be  = 4'b1111;
        case (size_q)
            SZ_BYTE: begin
                wdata   = {din_q[7:0], 24'h0};
                lane_be = 4'b1000;
            end
            SZ_HALF: begin
                wdata   = {din_q[15:0], 16'h0};
                lane_be = 4'b1100;
`ifdef MEM_ALIGN_CHECK_EN
                misalign = addr_q[0];
`else
                eff_addr[0] = 1'b0;
`endif
            end
            default: begin
`ifdef MEM_ALIGN_CHECK_EN
                misalign = |addr_q[1:0];
`else
                eff_addr[1:0] = 2'b00;
`endif
            end
        endcase
    end

    // A reset on the access edge must not commit the pending write.
    assign be = (access && !Clr && !misalign && rw_q == RW_WRITE) ? lane_be : 4'b0000;

    mem_byte_array #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (Clk),
        .addr  (eff_addr),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            rw_q        <= RW_READ;
            size_q      <= SZ_BYTE;
            sext_q      <= 1'b0;
            din_q       <= 32'h0;
            data_out_q  <= 32'h0;
            moc_q       <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q  <= 4'(WAIT_CYCLES);
                addr_q <= bus.Address[ADDR_W-1:0];
                rw_q   <= bus.RW;
                size_q <= bus.Size;
                sext_q <= bus.SignExt;
                din_q  <= bus.DataIn;
            end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (access) begin
                moc_q       <= 1'b1;
                align_err_q <= misalign;
                if (rw_q == RW_READ && !misalign) begin
                    data_out_q <= extend_load(size_q, sext_q, rdata);
                end
            end else if (state_q == ST_DONE && !bus.MOV) begin
                moc_q       <= 1'b0;
                align_err_q <= 1'b0;
            end
        end
    end

    assign bus.DataOut  = data_out_q;
    assign bus.MOC      = moc_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign bus.AlignErr = align_err_q;
`else
    assign bus.AlignErr = 1'b0;
`endif

endmodule
